// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one- or two-word instructions from a synchronous
// memory and holds them for the control unit. Optional accept counter under FETCH_PERF_EN.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter int          MEM_DEPTH = 191,
    parameter logic [7:0]  ENDOP     = 8'd51
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rd_data,
    output logic [7:0]  ir_opcode,
    output logic [15:0] ir_operand,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic [15:0] pc,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        OP_REQ  = 3'd0,
        OP_CAP  = 3'd1,
        IMM_REQ = 3'd2,
        IMM_CAP = 3'd3,
        HOLD    = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [31:0] DEPTH = MEM_DEPTH;

    state_t state;
    logic   pc_fault;
    logic   accept;

    // Handshake: an instruction transfers on any rising edge where ir_valid and
    // ir_ready are both 1; ir_valid never drops and the payload never changes
    // until that edge, and redirect/redirect_addr are only looked at on it.
    assign accept   = (state == HOLD) && ir_valid && ir_ready;
    assign mem_addr = pc;
    assign pc_fault = ({16'd0, pc} >= DEPTH);

    function automatic logic needs_operand(input logic [7:0] op);
        case (op)
            8'd38, 8'd41, 8'd48, 8'd49: needs_operand = 1'b1;
            default:                    needs_operand = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OP_REQ;
            pc         <= RESET_PC;
            ir_opcode  <= 8'd0;
            ir_operand <= 16'd0;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                OP_REQ: begin
                    if (pc_fault) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        fault  <= 1'b1;
                    end else begin
                        state <= OP_CAP;
                    end
                end
                OP_CAP: begin
                    ir_opcode <= mem_rd_data[7:0];
                    pc        <= pc + 16'd1;
                    if (needs_operand(mem_rd_data[7:0])) begin
                        state <= IMM_REQ;
                    end else begin
                        ir_operand <= 16'd0;
                        ir_valid   <= 1'b1;
                        state      <= HOLD;
                    end
                end
                IMM_REQ: begin
                    // pc already advanced past the opcode, so this checks the operand word
                    if (pc_fault) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        fault  <= 1'b1;
                    end else begin
                        state <= IMM_CAP;
                    end
                end
                IMM_CAP: begin
                    ir_operand <= mem_rd_data;
                    pc         <= pc + 16'd1;
                    ir_valid   <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        ir_valid <= 1'b0;
                        if (ir_opcode == ENDOP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            if (redirect) begin
                                pc <= redirect_addr;
                            end
                            state <= OP_REQ;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= OP_REQ;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 16'd0;
        end else if (accept && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous memory model, transaction-level reference of the
// fetch rules, directed scenarios followed by a randomized instruction stream.
module tb_instr_fetch;

    localparam int DEPTH = 191;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = 16'd0;
    logic [7:0]  ir_opcode;
    logic [15:0] ir_operand;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'd0;
    logic [15:0] pc;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [15:0] instr_count;
`endif

    instr_fetch #(.RESET_PC(16'd0), .MEM_DEPTH(DEPTH), .ENDOP(8'd51)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .ir_opcode     (ir_opcode),
        .ir_operand    (ir_operand),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault)
`ifdef FETCH_PERF_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    // clock / reset / memory
    always #5 clk = ~clk;

    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        mem_rd_data <= (mem_addr < 16'd256) ? mem[mem_addr[7:0]] : 16'h0000;
    end

    // scoreboard and reference state
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [15:0] m_pc;
    logic [7:0]  m_op;
    logic [15:0] m_operand;
    logic [15:0] m_count;
    logic [7:0]  two_ops [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_two_word(input logic [7:0] op);
        return (op == 8'd38) || (op == 8'd41) || (op == 8'd48) || (op == 8'd49);
    endfunction

    // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        ir_ready = 1'b0;
        redirect = 1'b0;
        #1;
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_opcode"}, 32'(ir_opcode), 32'd0);
        check({tag, "_operand"}, 32'(ir_operand), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 16'd0;
        m_count = 16'd0;
        exp_q.delete();
`ifdef FETCH_PERF_EN
        check({tag, "_count"}, 32'(instr_count), 32'd0);
`endif
    endtask

    // Predict the next instruction from memory and wait for it; pulse_at selects
    // the wait step at which a (to-be-ignored) redirect is driven, -1 for none.
    task automatic fetch_expect(input string tag, input int pulse_at);
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [23:0] item;
        int          exp_lat;
        int          lat;
        op = mem[m_pc[7:0]][7:0];
        if (is_two_word(op)) begin
            opnd = mem[8'(m_pc + 16'd1)];
            exp_lat = 4;
            m_pc = m_pc + 16'd2;
        end else begin
            opnd = 16'd0;
            exp_lat = 2;
            m_pc = m_pc + 16'd1;
        end
        exp_q.push_back({op, opnd});
        lat = 0;
        while (ir_valid !== 1'b1 && lat < 12) begin
            redirect = (lat == pulse_at);
            redirect_addr = 16'h0003;
            tick();
            lat++;
        end
        redirect = 1'b0;
        item = exp_q.pop_front();
        m_op = item[23:16];
        m_operand = item[15:0];
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_opcode"}, 32'(ir_opcode), 32'(m_op));
        check({tag, "_operand"}, 32'(ir_operand), 32'(m_operand));
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic stall(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            ir_ready = 1'b0;
            redirect = 1'($urandom_range(0, 1));
            redirect_addr = 16'($urandom);
            tick();
            check({tag, "_stall_valid"}, 32'(ir_valid), 32'd1);
            check({tag, "_stall_opcode"}, 32'(ir_opcode), 32'(m_op));
            check({tag, "_stall_operand"}, 32'(ir_operand), 32'(m_operand));
        end
        redirect = 1'b0;
    endtask

    task automatic accept(input string tag, input bit redir, input logic [15:0] addr);
        ir_ready = 1'b1;
        redirect = redir;
        redirect_addr = addr;
        tick();
        ir_ready = 1'b0;
        redirect = 1'b0;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_op != 8'd51 && redir) m_pc = addr;
        check({tag, "_acc_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_acc_mem_addr"}, 32'(mem_addr), 32'(m_pc));
        check({tag, "_acc_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_acc_halted"}, 32'(halted), 32'(m_op == 8'd51));
    endtask

    initial begin
        two_ops[0] = 8'd38; two_ops[1] = 8'd41; two_ops[2] = 8'd48; two_ops[3] = 8'd49;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'd38;  mem[1] = 16'd257;
        mem[9] = 16'd16;  mem[10] = 16'h0A11;
        mem[127] = 16'd49; mem[128] = 16'd9; mem[129] = 16'h0005;
        mem[186] = 16'd51; mem[190] = 16'd38;
        for (int a = 20; a < 120; a++) begin
            logic [7:0] op;
            if ($urandom_range(0, 1) == 1) op = two_ops[$urandom_range(0, 3)];
            else op = 8'($urandom);
            if (op == 8'd51) op = 8'd52;
            mem[a] = {8'($urandom), op};
            if ($urandom_range(0, 1) == 1) mem[a] = 16'($urandom) & 16'hFF00 | 16'(op);
        end

        do_reset("reset0");
        fetch_expect("loadim_w0", -1);
        accept("loadim_w0", 1'b1, 16'd9);
        fetch_expect("movr1ac", -1);
        stall("movr1ac", 4);
        accept("movr1ac", 1'b0, 16'h0000);
        fetch_expect("op17", -1);
        accept("op17", 1'b1, 16'd127);
        fetch_expect("jump127_a", -1);
        accept("jump127_a", 1'b1, 16'd9);
        fetch_expect("movr1ac_b", -1);
        accept("movr1ac_b", 1'b1, 16'd127);
        fetch_expect("jump127_pulse", 3);
        accept("jump127_pulse", 1'b0, 16'h0000);
        fetch_expect("op5", -1);
        accept("op5", 1'b1, 16'd20);

        for (int n = 0; n < 40; n++) begin
            bit          redir;
            logic [15:0] target;
            fetch_expect("rand", $urandom_range(0, 5) - 1);
            stall("rand", $urandom_range(0, 3));
            redir = (m_pc > 16'd100) || ($urandom_range(0, 3) == 0);
            target = 16'($urandom_range(20, 100));
            if (n == 39) begin
                redir = 1'b1;
                target = 16'd186;
            end
            accept("rand", redir, target);
        end
`ifdef FETCH_PERF_EN
        check("perf_rand_count", 32'(instr_count), 32'(m_count));
`endif

        fetch_expect("endop", -1);
        accept("endop", 1'b1, 16'd5);
        for (int i = 0; i < 20; i++) begin
            ir_ready = 1'($urandom_range(0, 1));
            redirect = 1'($urandom_range(0, 1));
            redirect_addr = 16'($urandom);
            tick();
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_fault", 32'(fault), 32'd0);
            check("halt_valid", 32'(ir_valid), 32'd0);
            check("halt_pc", 32'(pc), 32'd187);
        end
        ir_ready = 1'b0;
        redirect = 1'b0;

        do_reset("reset1");
        fetch_expect("fault_pre", -1);
        accept("fault_pre", 1'b1, 16'd190);
        repeat (2) tick();
        check("fault_early_halted", 32'(halted), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("fault_fault", 32'(fault), 32'd1);
            check("fault_halted", 32'(halted), 32'd1);
            check("fault_valid", 32'(ir_valid), 32'd0);
            check("fault_pc", 32'(pc), 32'(DEPTH));
            tick();
        end

        do_reset("reset2");
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("immcap_rst_pc", 32'(pc), 32'd0);
        check("immcap_rst_valid", 32'(ir_valid), 32'd0);
        check("immcap_rst_opcode", 32'(ir_opcode), 32'd0);
        do_reset("reset3");
        fetch_expect("after_rst", -1);
        accept("after_rst", 1'b1, 16'd9);
        fetch_expect("after_rst_b", -1);
        accept("after_rst_b", 1'b0, 16'h0000);
        fetch_expect("after_rst_c", -1);
        accept("after_rst_c", 1'b0, 16'h0000);
`ifdef FETCH_PERF_EN
        check("perf_three", 32'(instr_count), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
